// File: rtl/fp_mult_arbiter.sv
// rtl/fp_mult_arbiter.sv - round-robin arbiter sharing one FP32 multiplier between N_REQ requesters
// Includes the combinational FP_Multiplicator it drives from its operand registers.

module FP_Multiplicator (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        overflow,
   output logic        underflow
);
   logic              sign;
   logic [7:0]        ea, eb;
   logic [22:0]       ma, mb;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [24:0]       prod_top;
   logic [22:0]       frac;
   logic signed [9:0] exp_sum;

   assign sign   = a[31] ^ b[31];
   assign ea     = a[30:23];
   assign eb     = b[30:23];
   assign ma     = a[22:0];
   assign mb     = b[22:0];
   assign a_nan  = (ea == 8'hFF) && (ma != '0);
   assign b_nan  = (eb == 8'hFF) && (mb != '0);
   assign a_inf  = (ea == 8'hFF) && (ma == '0);
   assign b_inf  = (eb == 8'hFF) && (mb == '0);
   // Subnormal inputs are flushed to zero.
   assign a_zero = (ea == 8'h00);
   assign b_zero = (eb == 8'h00);

   // Only the top 25 bits of the 48-bit significand product matter; the rest is truncated.
   assign prod_top = 25'(({24'b0, 1'b1, ma} * {24'b0, 1'b1, mb}) >> 23);
   assign frac     = prod_top[24] ? prod_top[23:1] : prod_top[22:0];
   assign exp_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
                     + $signed({9'b0, prod_top[24]});

   always_comb begin
      result    = '0;
      overflow  = 1'b0;
      underflow = 1'b0;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         result = 32'h7FC0_0000;
      end else if (a_inf || b_inf) begin
         result = {sign, 8'hFF, 23'b0};
      end else if (a_zero || b_zero) begin
         result = {sign, 31'b0};
      end else if (exp_sum >= 10'sd255) begin
         result   = {sign, 8'hFF, 23'b0};
         overflow = 1'b1;
      end else if (exp_sum <= 10'sd0) begin
         result    = {sign, 31'b0};
         underflow = 1'b1;
      end else begin
         result = {sign, exp_sum[7:0], frac};
      end
   end
endmodule

module fp_mult_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req_valid,
   output logic [N_REQ-1:0]    req_ready,
   input  logic [N_REQ*32-1:0] req_a,
   input  logic [N_REQ*32-1:0] req_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [31:0]         rsp_result,
   output logic                rsp_overflow,
   output logic                rsp_underflow,
   output logic [ID_W-1:0]     rsp_id,
   output logic                busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state, state_next;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] grant_id;
   logic            grant_found;
   logic            accept;
   logic [31:0]     op_a, op_b;
   logic [ID_W-1:0] op_id;
   logic [31:0]     mul_result;
   logic            mul_overflow, mul_underflow;

   // Scan downward so the last hit is the lowest offset from ptr.
   always_comb begin
      int idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_id    = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (req_valid[idx]) begin
            grant_found = 1'b1;
            grant_id    = ID_W'(idx);
         end
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      req_ready  = '0;
      case (state)
         IDLE: begin
            if (grant_found) begin
               req_ready[grant_id] = 1'b1;
               accept              = 1'b1;
               state_next          = EXEC;
            end
         end
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   FP_Multiplicator u_mul (
      .a         (op_a),
      .b         (op_b),
      .result    (mul_result),
      .overflow  (mul_overflow),
      .underflow (mul_underflow)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         ptr           <= '0;
         op_a          <= '0;
         op_b          <= '0;
         op_id         <= '0;
         rsp_result    <= '0;
         rsp_overflow  <= 1'b0;
         rsp_underflow <= 1'b0;
         rsp_id        <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            op_a  <= req_a[32*grant_id +: 32];
            op_b  <= req_b[32*grant_id +: 32];
            op_id <= grant_id;
            ptr   <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
         end
         if (state == EXEC) begin
            rsp_result    <= mul_result;
            rsp_overflow  <= mul_overflow;
            rsp_underflow <= mul_underflow;
            rsp_id        <= op_id;
         end
      end
   end

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb/tb_fp_mult_arbiter.sv - self-checking bench for fp_mult_arbiter
// Directed vector table, multi-cycle corner sequences and a randomized scoreboard run.

module tb_fp_mult_arbiter;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req_valid, req_ready;
   logic [N*32-1:0] req_a, req_b;
   logic         rsp_valid, rsp_ready;
   logic [31:0]  rsp_result;
   logic         rsp_overflow, rsp_underflow;
   logic [1:0]   rsp_id;
   logic         busy;

   int vectors = 0;
   int miscompares = 0;

   fp_mult_arbiter #(.N_REQ(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
      .rsp_underflow(rsp_underflow), .rsp_id(rsp_id), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        ovf;
      logic        unf;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
   endtask

   // Exactly representable operand: 4 significant fraction bits, moderate exponent.
   function automatic logic [31:0] gen_op();
      logic [31:0] v;
      v = {1'($urandom), 8'(100 + $urandom % 55), 4'($urandom), 19'b0};
      return v;
   endfunction

   // Exact product of two gen_op values: ((16+m1)/16)*((16+m2)/16) * 2^(e1+e2-254).
   function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
      int p, e, frac;
      p = (16 + int'(a[22:19])) * (16 + int'(b[22:19]));
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p >= 512) begin
         e++;
         frac = (p - 512) << 14;
      end else begin
         frac = (p - 256) << 15;
      end
      return {a[31] ^ b[31], 8'(e), 23'(frac)};
   endfunction

   task automatic run_op(input int id, input vec_t v);
      req_valid = 4'(1 << id);
      req_a[32*id +: 32] = v.a;
      req_b[32*id +: 32] = v.b;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("op_grant", 32'(req_ready), 32'd1 << id);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      check("op_exec_no_rsp", 32'(rsp_valid), 32'd0);
      next_cycle();
      @(negedge clk);
      check("op_rsp_valid", 32'(rsp_valid), 32'd1);
      check("op_result", rsp_result, v.r);
      check("op_overflow", 32'(rsp_overflow), 32'(v.ovf));
      check("op_underflow", 32'(rsp_underflow), 32'(v.unf));
      check("op_id", 32'(rsp_id), 32'(id));
      next_cycle();
   endtask

   vec_t vtab[8];
   logic [N-1:0] pending;
   logic [31:0]  op_a[N], op_b[N];
   int waits[N];
   int mptr, age, g, exp_id;
   logic inflight;
   logic [31:0] exp_r;

   initial begin
      vtab[0] = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0};
      vtab[1] = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0};
      vtab[2] = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1};
      vtab[3] = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0};
      vtab[4] = '{32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 1'b0, 1'b0};
      vtab[5] = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0};
      vtab[6] = '{32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, 1'b0};
      vtab[7] = '{32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 1'b0, 1'b0};

      req_a = '0; req_b = '0;
      do_reset();
      @(negedge clk);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_result", rsp_result, 32'd0);
      check("rst_id", 32'(rsp_id), 32'd0);
      check("rst_flags", 32'({rsp_overflow, rsp_underflow}), 32'd0);
      rsp_ready = 1'b1;
      repeat (2) begin
         next_cycle();
         @(negedge clk);
         check("idle_no_valid", 32'({busy, req_ready}), 32'd0);
      end
      next_cycle();

      // Single op on requester 2 first, then the whole table.
      run_op(2, vtab[0]);
      for (int i = 0; i < 8; i++) run_op(i % N, vtab[i]);

      // Fairness: all requesters valid from reset release.
      do_reset();
      for (int i = 0; i < N; i++) begin
         op_a[i] = gen_op(); op_b[i] = gen_op();
         req_a[32*i +: 32] = op_a[i]; req_b[32*i +: 32] = op_b[i];
      end
      req_valid = '1; rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("fair_grant", 32'(req_ready), 32'd1 << (k % N));
         next_cycle();
         @(negedge clk);
         check("fair_exec_ready", 32'(req_ready), 32'd0);
         next_cycle();
         @(negedge clk);
         check("fair_rsp_id", 32'(rsp_id), 32'(k % N));
         check("fair_result", rsp_result, model_mul(op_a[k % N], op_b[k % N]));
         next_cycle();
      end

      // Backpressure with requester 1 still valid.
      do_reset();
      req_valid = 4'b0010; rsp_ready = 1'b0;
      req_a[63:32] = 32'h4000_0000; req_b[63:32] = 32'h4040_0000;
      @(negedge clk);
      check("bp_grant", 32'(req_ready), 32'h2);
      next_cycle();
      next_cycle();
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_result", rsp_result, 32'h40C0_0000);
         check("bp_id", 32'(rsp_id), 32'd1);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         next_cycle();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", 32'(rsp_valid), 32'd1);
      next_cycle();
      @(negedge clk);
      check("bp_regrant", 32'(req_ready), 32'h2);
      next_cycle();
      req_valid = '0;
      repeat (3) next_cycle();

      // Reset while in EXEC: op dropped, ptr back to 0.
      do_reset();
      req_valid = 4'b0100; rsp_ready = 1'b1;
      @(negedge clk);
      check("rm_grant", 32'(req_ready), 32'h4);
      next_cycle();
      req_valid = '0;
      rst_n = 1'b0;
      @(negedge clk);
      check("rm_in_exec", 32'(busy), 32'd1);
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      check("rm_busy", 32'(busy), 32'd0);
      check("rm_rsp_valid", 32'(rsp_valid), 32'd0);
      for (int j = 0; j < 4; j++) begin
         next_cycle();
         @(negedge clk);
         check("rm_no_rsp", 32'(rsp_valid), 32'd0);
      end
      next_cycle();
      req_valid = '1;
      @(negedge clk);
      check("rm_ptr_zero", 32'(req_ready), 32'h1);
      next_cycle();
      req_valid = '0;
      repeat (3) next_cycle();

      // Pointer wrap: 3 alone, then 0 and 3 together.
      do_reset();
      req_valid = 4'b1000; rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("wrap_grant", 32'(req_ready), (k == 1) ? 32'h1 : 32'h8);
         next_cycle();
         req_valid = 4'b1001;
         next_cycle();
         @(negedge clk);
         check("wrap_rsp_id", 32'(rsp_id), (k == 1) ? 32'd0 : 32'd3);
         next_cycle();
      end

      // Randomized traffic against a transaction-level model.
      do_reset();
      pending = '0; mptr = 0; inflight = 1'b0; age = 0; exp_r = '0; exp_id = 0;
      for (int i = 0; i < N; i++) waits[i] = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!pending[i] && ($urandom % 3 == 0)) begin
               pending[i] = 1'b1; waits[i] = 0;
               op_a[i] = gen_op(); op_b[i] = gen_op();
               req_a[32*i +: 32] = op_a[i]; req_b[32*i +: 32] = op_b[i];
            end
         end
         req_valid = pending;
         rsp_ready = ($urandom % 3) != 0;
         @(negedge clk);
         g = -1;
         if (!inflight) begin
            for (int k = N - 1; k >= 0; k--)
               if (pending[(mptr + k) % N]) g = (mptr + k) % N;
         end
         check("rnd_req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
         check("rnd_busy", 32'(busy), 32'(inflight));
         check("rnd_rsp_valid", 32'(rsp_valid), 32'(inflight && age >= 2));
         if (inflight && age >= 2 && rsp_ready) begin
            check("rnd_result", rsp_result, exp_r);
            check("rnd_id", 32'(rsp_id), 32'(exp_id));
            inflight = 1'b0;
         end else if (g >= 0) begin
            check("rnd_fair_wait", 32'(waits[g] <= N - 1), 32'd1);
            for (int i = 0; i < N; i++) if (pending[i] && i != g) waits[i]++;
            exp_r = model_mul(op_a[g], op_b[g]);
            exp_id = g;
            pending[g] = 1'b0;
            mptr = (g + 1) % N;
            inflight = 1'b1;
            age = 1;
         end else if (inflight && age < 2) begin
            age++;
         end
         next_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
